// File: rtl/decode_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : decode_hazard_scoreboard
// Description : Decode-stage register-hazard and flush controller. Tracks
//               outstanding register writes in a 32-entry scoreboard. Stalls
//               the ID instruction on RAW/WAW hazards and holds flush for
//               FLUSH_CYCLES cycles after a taken branch.
//               Optional macro HAZARD_PERF_COUNT_EN adds stall/flush
//               cycle counters (stall_count, flush_count).
// Revision    : 1.0 - initial release
// ============================================================================
module decode_hazard_scoreboard #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  id_rd_addr,
    input  logic        id_reg_write,
    input  logic        ex_branch_taken,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd_addr,
    output logic        stall,
    output logic        flush,
    output logic        id_ex_bubble,
    output logic        issue,
`ifdef HAZARD_PERF_COUNT_EN
    output logic [31:0] stall_count,
    output logic [31:0] flush_count,
`endif
    output logic [31:0] pending
);

    localparam logic [1:0] c_st_run   = 2'd0;
    localparam logic [1:0] c_st_stall = 2'd1;
    localparam logic [1:0] c_st_flush = 2'd2;

    // Value loaded on a taken branch: the number of cycles spent in FLUSH
    // after the branch cycle itself.
    localparam logic [2:0] c_flush_init = 3'(FLUSH_CYCLES - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nxt;
    logic [31:0] r_pending;
    logic [31:0] w_pending_nxt;
    logic [31:0] w_set;
    logic [31:0] w_clr;
    logic        w_hz_rs1;
    logic        w_hz_rs2;
    logic        w_hz_rd;
    logic        w_hazard;
    logic        w_flush;
    logic        w_stall;

    // Hazard detection against the registered scoreboard only; x0 never hazards.
    always_comb begin
        w_hz_rs1 = id_uses_rs1  && (id_rs1_addr != 5'd0) && r_pending[id_rs1_addr];
        w_hz_rs2 = id_uses_rs2  && (id_rs2_addr != 5'd0) && r_pending[id_rs2_addr];
        w_hz_rd  = id_reg_write && (id_rd_addr  != 5'd0) && r_pending[id_rd_addr];
        w_hazard = id_valid && (w_hz_rs1 || w_hz_rs2 || w_hz_rd);
    end

    // Pipeline control outputs; flush always takes priority over stall.
    always_comb begin
        w_flush      = ex_branch_taken || (r_state == c_st_flush);
        w_stall      = w_hazard && !w_flush;
        flush        = w_flush;
        stall        = w_stall;
        id_ex_bubble = w_flush || w_stall || !id_valid;
        issue        = id_valid && !w_stall && !w_flush;
        pending      = r_pending;
    end

    // Next-state logic: a taken branch (re)starts the flush sequence from any state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (ex_branch_taken) begin
            if (c_flush_init != 3'd0) begin
                w_state_nxt = c_st_flush;
                w_cnt_nxt   = c_flush_init;
            end else begin
                // A single-cycle flush is covered entirely by the branch cycle.
                w_state_nxt = c_st_run;
                w_cnt_nxt   = 3'd0;
            end
        end else begin
            case (r_state)
                c_st_run: begin
                    if (w_hazard) begin
                        w_state_nxt = c_st_stall;
                    end
                end
                c_st_stall: begin
                    if (!w_hazard) begin
                        w_state_nxt = c_st_run;
                    end
                end
                c_st_flush: begin
                    // Counter holds the remaining FLUSH cycles including this one.
                    if (r_cnt <= 3'd1) begin
                        w_state_nxt = c_st_run;
                        w_cnt_nxt   = 3'd0;
                    end else begin
                        w_cnt_nxt   = r_cnt - 3'd1;
                    end
                end
                default: begin
                    w_state_nxt = c_st_run;
                    w_cnt_nxt   = 3'd0;
                end
            endcase
        end
    end

    // State and flush counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_run;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Scoreboard set/clear masks; set is applied after clear so set wins.
    always_comb begin
        w_clr = 32'd0;
        w_set = 32'd0;
        if (wb_reg_write && (wb_rd_addr != 5'd0)) begin
            w_clr = 32'd1 << wb_rd_addr;
        end
        if (issue && id_reg_write && (id_rd_addr != 5'd0)) begin
            w_set = 32'd1 << id_rd_addr;
        end
        w_pending_nxt = ((r_pending & ~w_clr) | w_set) & ~32'd1;
    end

    // Pending-write scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 32'd0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

`ifdef HAZARD_PERF_COUNT_EN
    logic [31:0] r_stall_count;
    logic [31:0] r_flush_count;

    // Free-running cycle counters for stall and flush, wrapping naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= 32'd0;
            r_flush_count <= 32'd0;
        end else begin
            if (w_stall) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
            if (w_flush) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;
`endif

endmodule
`default_nettype wire

// File: doc/decode_hazard_scoreboard.md
# decode_hazard_scoreboard

Register-hazard and flush controller for the decode stage. It tracks which architectural registers have a write outstanding in EX/MEM/WB (a 32-entry pending-write scoreboard). It stalls the instruction in ID on RAW/WAW hazards and sequences pipeline flushes after a taken branch. It drives the hold/squash controls of the PC, the IF/ID register and the ID/EX register.

## Interface
- FLUSH_CYCLES, 2: number of cycles flush is held after a taken branch (1..7).
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1_addr, id_rs2_addr  in  5 each  source register addresses of the ID instruction.
- id_uses_rs1, id_uses_rs2  in  1 each  the ID instruction actually reads that source.
- id_rd_addr  in  5  destination of the ID instruction.
- id_reg_write  in  1  the ID instruction writes rd.
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle.
- wb_reg_write  in  1  writeback commits a register this cycle.
- wb_rd_addr  in  5  writeback destination.
- stall  out  1  hold PC and IF/ID.
- flush  out  1  squash IF/ID contents.
- id_ex_bubble  out  1  load zeroed control signals into ID/EX.
- issue  out  1  the ID instruction advances into EX this cycle.
- pending  out  32  scoreboard bits, debug visibility; bit 0 always 0.

## Operation
- State machine states are RUN, STALL and FLUSH. Reset enters RUN.
- Hazard (combinational, registered scoreboard only, no same-cycle bypass): id_valid and any of the following:
  - id_uses_rs1 with pending[rs1]
  - id_uses_rs2 with pending[rs2]
  - id_reg_write with pending[rd] (WAW)
- Register x0 is never a hazard. It is never set pending.
- RUN:
  - ex_branch_taken goes to FLUSH with counter=FLUSH_CYCLES-1.
  - Otherwise a hazard goes to STALL.
  - Otherwise stays in RUN.
- STALL:
  - ex_branch_taken goes to FLUSH; flush has priority over stall.
  - Otherwise, no hazard goes to RUN.
- FLUSH: counter decrements each cycle. At 0 it goes to RUN, or to FLUSH again if ex_branch_taken.
- Outputs:
  - flush = ex_branch_taken or state==FLUSH.
  - stall = hazard and !flush.
  - id_ex_bubble = flush or stall or !id_valid.
  - issue = id_valid and !stall and !flush.
- Scoreboard update at the clock edge:
  - Clear: wb_reg_write and wb_rd_addr!=0 clears that bit.
  - Set: issue and id_reg_write and id_rd_addr!=0 sets that bit.
  - Set and clear of the same bit in one cycle cannot occur, because the WAW check blocks issue. If it is forced, set wins.

## Timing
- Reset values:
  - state=RUN, pending=0, counter=0.
  - With id_valid=0, ex_branch_taken=0: stall=0, flush=0, id_ex_bubble=1, issue=0.
- stall, flush, issue and id_ex_bubble are combinational from inputs plus registered state; there is zero-cycle latency from hazard to stall.
- Writeback clear is visible in the cycle after the wb edge. A dependent instruction issues one cycle after its producer's writeback cycle.
- A taken branch yields exactly FLUSH_CYCLES consecutive flush cycles: the branch cycle plus FLUSH_CYCLES-1 in FLUSH. A second taken branch restarts the count.
- Reset mid-stall or mid-flush returns to RUN and clears all pending bits in the same edge.

## Configuration
- HAZARD_PERF_COUNT_EN defined: adds outputs stall_count and flush_count, 32 bits each, reset to 0.
  - stall_count increments on each cycle stall=1.
  - flush_count increments on each cycle flush=1.
  - Both wrap modulo 2^32.
- Undefined: the counters and ports are absent; all other behaviour is identical.

## Test plan
- Reset then idle -> pending=0, stall=0, flush=0, issue=0, id_ex_bubble=1.
- Issue with rd=x5, id_reg_write=1, then ID reads rs1=x5 -> stall=1 until the cycle after wb_rd_addr=5 with wb_reg_write=1; then issue=1 and pending[5]=0.
- Issue writing x0, then ID reads x0 -> pending[0]=0 and no stall.
- WAW: pending[7]=1, ID writes x7 with no sources -> stall=1; released after writeback of x7.
- Stall on x3 while ex_branch_taken=1 -> flush=1, stall=0, issue=0. With FLUSH_CYCLES=2, flush is high exactly 2 cycles, then RUN.
- With HAZARD_PERF_COUNT_EN: 3 stall cycles plus one taken branch -> stall_count=3, flush_count=2.
